// File: rtl/parallel_multiplier.sv
// Unsigned WIDTH x WIDTH array multiplier (AND-gated partial products, ripple-carry rows) with one output register.
// Latency 1 cycle, accepts new operands every cycle; no handshake, never stalls.
module parallel_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] f
);

  logic [2*WIDTH-1:0] f_d;
  logic [2*WIDTH-1:0] f_q;

  // Row k's running sum is WIDTH+1 bits; its MSB is that row's carry-out.
  for (genvar k = 0; k < WIDTH; k++) begin : g_row
    logic [WIDTH:0] sum;

    if (k == 0) begin : g_pass
      assign sum = {1'b0, A & {WIDTH{B[0]}}};
    end else begin : g_rca
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic pp;
        logic addend;
        logic ci;
        logic co;

        assign pp     = A[i] & B[k];
        assign addend = g_row[k-1].sum[i+1];
        if (i == 0) begin : g_ha
          assign ci = 1'b0;
        end else begin : g_fa
          assign ci = g_bit[i-1].co;
        end
        assign sum[i] = pp ^ addend ^ ci;
        assign co     = (pp & addend) | (ci & (pp ^ addend));
      end
      assign sum[WIDTH] = g_bit[WIDTH-1].co;
    end

    if (k < WIDTH - 1) begin : g_lsb
      assign f_d[k] = sum[0];
    end else begin : g_top
      assign f_d[2*WIDTH-1:WIDTH-1] = sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q <= '0;
    end else begin
      f_q <= f_d;
    end
  end

  assign f = f_q;

endmodule

// File: tb/tb_parallel_multiplier.sv
// Bench for parallel_multiplier: directed vectors with literal products plus a per-cycle reference-model check.
module tb_parallel_multiplier;

  logic        clk;
  logic        rst_n;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [15:0] f;

  int n_chk  = 0;
  int n_fail = 0;
  bit running = 1'b0;

  logic [15:0] exp_f;

  parallel_multiplier #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .f     (f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: registered exact product, cleared asynchronously by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_f <= 16'h0000;
    else        exp_f <= 16'(A) * 16'(B);
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (running) chk("model", f, exp_f);
  end

  task automatic apply(input string name, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] req);
    @(negedge clk);
    A = a;
    B = b;
    @(posedge clk);
    #1 chk(name, f, req);
  endtask

  initial begin
    rst_n = 1'b1;
    A     = 8'hFF;
    B     = 8'hFF;

    // Async reset with no clock edge between assertion and check.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", f, 16'h0000);
    running = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_hold", f, 16'h0000);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("reset_release", f, 16'hFE01);

    apply("ff_x_06", 8'hFF, 8'h06, 16'h05FA);
    apply("ff_x_cd", 8'hFF, 8'hCD, 16'hCC33);
    apply("ff_x_aa", 8'hFF, 8'hAA, 16'hA956);
    apply("06_x_aa", 8'h06, 8'hAA, 16'h03FC);
    apply("aa_x_06", 8'hAA, 8'h06, 16'h03FC);
    apply("zero_a",  8'h00, 8'hFF, 16'h0000);
    apply("zero_b",  8'hB7, 8'h00, 16'h0000);
    apply("one_a",   8'h01, 8'hB7, 16'h00B7);
    apply("one_b",   8'h5C, 8'h01, 16'h005C);
    apply("80_x_80", 8'h80, 8'h80, 16'h4000);
    apply("ff_x_ff", 8'hFF, 8'hFF, 16'hFE01);

    // Back-to-back operands, one per cycle.
    apply("pipe0", 8'h12, 8'h34, 16'h03A8);
    apply("pipe1", 8'h0F, 8'h0F, 16'h00E1);
    apply("pipe2", 8'h10, 8'h10, 16'h0100);
    apply("pipe3", 8'hC8, 8'h03, 16'h0258);

    // Operand change between edges must not reach f until the next edge.
    apply("hold_a", 8'h05, 8'h05, 16'h0019);
    @(negedge clk);
    #2 A = 8'h07;
    #1 chk("hold_between_edges", f, 16'h0019);
    @(posedge clk);
    #1 chk("after_change", f, 16'h0023);

    // Mid-stream reset discards in-flight operands.
    @(negedge clk);
    A = 8'h33;
    B = 8'h44;
    #2 rst_n = 1'b0;
    #1 chk("midstream_reset", f, 16'h0000);
    @(posedge clk);
    #1 chk("midstream_hold", f, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("midstream_release", f, 16'h0D8C);

    // Random operands with occasional async reset pulses.
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      A = 8'($urandom);
      B = 8'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
        #1 chk("rand_reset", f, 16'h0000);
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    running = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
